// File: rtl/prenc83_reg.sv
// Registered priority encoder: reports the index of the highest set request bit
// one clock after it is presented, with an Idle flag when no request is active.
// N must be a power of two (>= 2) and W must equal log2(N).
module prenc83_reg #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   output logic [W-1:0] Y,
   output logic         Idle
);

   logic [W-1:0] idx;
   logic         none;
   logic [W-1:0] y_q;
   logic         idle_q;

   // Priority chain: scanning upward, a later (higher) set bit overrides lower ones.
   always_comb begin
      idx  = '0;
      none = 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
         if (A[i]) begin
            idx  = W'(i);
            none = 1'b0;
         end
      end
   end

   // Output registers; reset forces the "no request" encoding immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q    <= '0;
         idle_q <= 1'b1;
      end else begin
         y_q    <= idx;
         idle_q <= none;
      end
   end

   assign Y    = y_q;
   assign Idle = idle_q;

endmodule

// File: tb/tb_prenc83_reg.sv
// Self-checking bench for prenc83_reg: directed scenarios plus randomized
// stimulus checked against a behavioural priority-encoder model.
module tb_prenc83_reg;

   logic       clk;
   logic       rst_n;
   logic [7:0] A;
   logic [2:0] Y;
   logic       Idle;

   int checks;
   int failures;

   prenc83_reg #(
      .N(8),
      .W(3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (A),
      .Y    (Y),
      .Idle (Idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: search from the top bit down; the first set bit found wins.
   function automatic logic [2:0] model_y(input logic [7:0] a);
      for (int i = 7; i >= 0; i--) begin
         if (a[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   function automatic logic model_idle(input logic [7:0] a);
      return (a == 8'h00);
   endfunction

   // Apply A, then sample just after the next rising edge.
   task automatic apply(input logic [7:0] a);
      A = a;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      A     = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (Y !== 3'd0 || Idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold cycle %0d: Y=%0d Idle=%b, want Y=0 Idle=1", i, Y, Idle);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (Y !== 3'd7 || Idle !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: Y=%0d Idle=%b, want Y=7 Idle=0", Y, Idle);
      end
   endtask

   task automatic test_onehot();
      for (int i = 0; i < 8; i++) begin
         logic [7:0] a;
         a = 8'h01 << i;
         apply(a);
         checks++;
         if (Y !== 3'(i) || Idle !== 1'b0) begin
            failures++;
            $display("FAIL onehot A=%h: Y=%0d Idle=%b, want Y=%0d Idle=0", a, Y, Idle, i);
         end
      end
   endtask

   task automatic test_priority();
      logic [7:0] pats [4];
      logic [2:0] exps [4];
      pats = '{8'h44, 8'hF0, 8'hCF, 8'h03};
      exps = '{3'd6, 3'd7, 3'd7, 3'd1};
      for (int i = 0; i < 4; i++) begin
         apply(pats[i]);
         checks++;
         if (Y !== exps[i] || Idle !== 1'b0) begin
            failures++;
            $display("FAIL priority A=%h: Y=%0d Idle=%b, want Y=%0d Idle=0",
                     pats[i], Y, Idle, exps[i]);
         end
      end
   endtask

   task automatic test_idle();
      apply(8'h00);
      checks++;
      if (Y !== 3'd0 || Idle !== 1'b1) begin
         failures++;
         $display("FAIL idle_zero: Y=%0d Idle=%b, want Y=0 Idle=1", Y, Idle);
      end
      apply(8'h01);
      checks++;
      if (Y !== 3'd0 || Idle !== 1'b0) begin
         failures++;
         $display("FAIL idle_bit0: Y=%0d Idle=%b, want Y=0 Idle=0", Y, Idle);
      end
   endtask

   task automatic test_timing();
      apply(8'h80);
      checks++;
      if (Y !== 3'd7 || Idle !== 1'b0) begin
         failures++;
         $display("FAIL timing_first: Y=%0d Idle=%b, want Y=7 Idle=0", Y, Idle);
      end
      #2;
      A = 8'h02;
      #2;
      checks++;
      if (Y !== 3'd7 || Idle !== 1'b0) begin
         failures++;
         $display("FAIL timing_hold: Y=%0d Idle=%b, want Y=7 Idle=0", Y, Idle);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Y !== 3'd1 || Idle !== 1'b0) begin
         failures++;
         $display("FAIL timing_update: Y=%0d Idle=%b, want Y=1 Idle=0", Y, Idle);
      end
   endtask

   task automatic test_async_reset();
      apply(8'h20);
      checks++;
      if (Y !== 3'd5 || Idle !== 1'b0) begin
         failures++;
         $display("FAIL async_pre: Y=%0d Idle=%b, want Y=5 Idle=0", Y, Idle);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (Y !== 3'd0 || Idle !== 1'b1) begin
         failures++;
         $display("FAIL async_assert: Y=%0d Idle=%b, want Y=0 Idle=1", Y, Idle);
      end
      #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (Y !== 3'd0 || Idle !== 1'b1) begin
         failures++;
         $display("FAIL async_release_hold: Y=%0d Idle=%b, want Y=0 Idle=1", Y, Idle);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Y !== 3'd5 || Idle !== 1'b0) begin
         failures++;
         $display("FAIL async_recover: Y=%0d Idle=%b, want Y=5 Idle=0", Y, Idle);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         logic [7:0] a;
         a = 8'($urandom);
         if ($urandom_range(0, 7) == 0) a = 8'h00;
         else if ($urandom_range(0, 3) == 0) a = 8'h01 << $urandom_range(0, 7);
         apply(a);
         checks++;
         if (Y !== model_y(a) || Idle !== model_idle(a)) begin
            failures++;
            $display("FAIL random A=%h: Y=%0d Idle=%b, want Y=%0d Idle=%b",
                     a, Y, Idle, model_y(a), model_idle(a));
         end
      end
   endtask

   // Back-to-back random values with a mid-cycle glitch on A that must be ignored.
   task automatic test_back_to_back();
      for (int n = 0; n < 50; n++) begin
         logic [7:0] a;
         logic [7:0] junk;
         a    = 8'($urandom);
         junk = 8'($urandom);
         A    = junk;
         #3;
         A    = a;
         @(posedge clk);
         #2;
         A = ~a;
         #1;
         checks++;
         if (Y !== model_y(a) || Idle !== model_idle(a)) begin
            failures++;
            $display("FAIL back_to_back A=%h: Y=%0d Idle=%b, want Y=%0d Idle=%b",
                     a, Y, Idle, model_y(a), model_idle(a));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      A        = 8'h00;
      test_reset();
      test_onehot();
      test_priority();
      test_idle();
      test_timing();
      test_async_reset();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/prenc83_reg.md
Name: prenc83_reg

Overview:
- 8-to-3 priority encoder with registered outputs.
- Reports the index of the highest-numbered asserted input bit, plus an Idle flag when no input bit is set.
- Used as a request-arbitration and index-encoding stage in the datapath.
- The outputs are registered on a single clock, so downstream logic sees glitch-free, one-cycle-delayed results.

Parameters:
- N, 8, number of request inputs; must be a power of two and at least 2.
- W, 3, output index width; must equal log2(N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  N  request vector; bit i set means request i is active.
- Y  output  W  registered index of the highest set bit of A.
- Idle  output  1  registered flag; 1 when A had no bits set.

Behaviour:
- Reset: asynchronous and active-low.
  - While rst_n = 0: Y = 0 and Idle = 1, independent of clk.
  - The first update happens at the first rising clk edge after rst_n returns to 1.
- Encoding function (combinational, internal):
  - idx = the largest i such that A[i] = 1. The highest index has priority; all lower set bits are ignored.
  - If A = 0: idx = 0 and none = 1. Otherwise none = 0.
- Registering:
  - On each rising clk edge with rst_n = 1: Y <= idx and Idle <= none.
  - Latency is exactly one cycle from A to Y/Idle. There is no enable; outputs follow A every cycle.
- Outputs change only on a clk edge or on reset assertion.
- A changing between edges has no effect until the next edge. No glitches are permitted on the outputs.
- Y = 0 with Idle = 0 means A[0] was the only set bit. Y = 0 with Idle = 1 means no request.
- Consumers must qualify Y with Idle.
- Multiple set bits: only the highest index is reported. Examples:
  - A = 8'hFF gives Y = 7.
  - A = 8'h44 gives Y = 6.
- Reset asserted mid-operation immediately forces Y = 0 and Idle = 1. Any pending encode is lost.
- Implementation must be synthesizable:
  - Encoding uses a parameterized loop or priority chain, scaled by N.
  - No latches; the combinational block assigns a default to every signal.
- No X propagation: with a fully defined A, Y and Idle are fully defined one cycle later.

Test Plan:
- Reset: hold rst_n = 0 with A = 8'hFF and toggle clk -> Y = 0, Idle = 1 throughout. Release rst_n; after 1 edge -> Y = 7, Idle = 0.
- One-hot sweep: apply A = 01, 02, 04, 08, 10, 20, 40, 80 (hex) on successive cycles -> Y = 0, 1, 2, 3, 4, 5, 6, 7 respectively, one cycle later, Idle = 0 each time.
- Multi-bit priority: A = 8'h44 -> Y = 6. A = 8'hF0 -> Y = 7. A = 8'hCF -> Y = 7. A = 8'h03 -> Y = 1. Idle = 0 in all cases.
- Idle: A = 8'h00 -> Y = 0, Idle = 1. Then A = 8'h01 -> Y = 0, Idle = 0. Checks that Idle is the only distinction between the two.
- Latency and timing: change A mid-cycle from 8'h80 to 8'h02 -> outputs hold Y = 7 until the next rising edge, then Y = 1. No change between edges.
- Async reset mid-run: with Y = 5 (A = 8'h20), pulse rst_n low between clock edges -> Y = 0 and Idle = 1 immediately. After release and the next edge -> Y = 5 again.
